// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its read ports.
// Holds the reorder-buffer geometry; no logic, so no latency or backpressure.
package regfile_pkg;

    localparam int ROB_A     = 4;
    localparam int ROB_DEPTH = 1 << ROB_A;
    localparam int ROB_R     = ROB_A;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic [31:0]      value;
        logic             busy;
        logic [ROB_R-1:0] tag;
    } reg_entry_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: resolves an operand from storage, the retiring commit or the ROB.
// Purely combinational with zero latency; no backpressure.
module regfile_rd_port
    import regfile_pkg::*;
(
    input  logic [4:0]       get_id,
    input  logic [31:0]      ent_val,
    input  logic             ent_busy,
    input  logic [ROB_R-1:0] ent_tag,
    input  logic             is_commit,
    input  logic [ROB_R-1:0] set_from_rob_id,
    input  logic [31:0]      set_val,
    input  logic             rob_avail,
    input  logic [31:0]      rob_val,
    output logic [31:0]      val,
    output logic             has_dep,
    output logic [ROB_R-1:0] dep,
    output logic [ROB_R-1:0] get_rob_id
);

    assign get_rob_id = ent_tag;

    always_comb begin
        val     = 32'd0;
        has_dep = 1'b0;
        dep     = '0;
        if (get_id == 5'd0) begin
            val = 32'd0;
        end else if (!ent_busy) begin
            val = ent_val;
        end else if (is_commit && (set_from_rob_id == ent_tag)) begin
            // the producer retires this very cycle: bypass its result
            val = set_val;
        end else if (rob_avail) begin
            val = rob_val;
        end else begin
            has_dep = 1'b1;
            dep     = ent_tag;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags; reads are combinational and see pre-edge state.
// Updates one cycle after commit/rename; rdy_in low freezes all state.
module regfile
    import regfile_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             is_commit,
    input  logic [4:0]       set_id,
    input  logic [31:0]      set_val,
    input  logic [ROB_R-1:0] set_from_rob_id,
    input  logic [4:0]       set_dep_id,
    input  logic [ROB_R-1:0] set_dep_Q,
    input  logic [4:0]       get_id_1,
    input  logic [4:0]       get_id_2,
    output logic [31:0]      val_1,
    output logic [31:0]      val_2,
    output logic             has_dep_1,
    output logic             has_dep_2,
    output logic [ROB_R-1:0] dep_1,
    output logic [ROB_R-1:0] dep_2,
    output logic [ROB_R-1:0] get_rob_id_1,
    output logic [ROB_R-1:0] get_rob_id_2,
    input  logic             rob_avail_1,
    input  logic             rob_avail_2,
    input  logic [31:0]      rob_val_1,
    input  logic [31:0]      rob_val_2
);

    reg_entry_t regs [NUM_REGS];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    regs[i].busy <= 1'b0;
                end
            end else begin
                if (is_commit && (set_id != 5'd0)) begin
                    regs[set_id].value <= set_val;
                    if (regs[set_id].busy && (regs[set_id].tag == set_from_rob_id)) begin
                        regs[set_id].busy <= 1'b0;
                    end
                end
                // a same-cycle rename is assigned last so it overrides the commit's busy clear
                if (set_dep_id != 5'd0) begin
                    regs[set_dep_id].busy <= 1'b1;
                    regs[set_dep_id].tag  <= set_dep_Q;
                end
            end
        end
    end

    regfile_rd_port u_rd_1 (
        .get_id          (get_id_1),
        .ent_val         (regs[get_id_1].value),
        .ent_busy        (regs[get_id_1].busy),
        .ent_tag         (regs[get_id_1].tag),
        .is_commit       (is_commit),
        .set_from_rob_id (set_from_rob_id),
        .set_val         (set_val),
        .rob_avail       (rob_avail_1),
        .rob_val         (rob_val_1),
        .val             (val_1),
        .has_dep         (has_dep_1),
        .dep             (dep_1),
        .get_rob_id      (get_rob_id_1)
    );

    regfile_rd_port u_rd_2 (
        .get_id          (get_id_2),
        .ent_val         (regs[get_id_2].value),
        .ent_busy        (regs[get_id_2].busy),
        .ent_tag         (regs[get_id_2].tag),
        .is_commit       (is_commit),
        .set_from_rob_id (set_from_rob_id),
        .set_val         (set_val),
        .rob_avail       (rob_avail_2),
        .rob_val         (rob_val_2),
        .val             (val_2),
        .has_dep         (has_dep_2),
        .dep             (dep_2),
        .get_rob_id      (get_rob_id_2)
    );

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have these ports:
  clk_in  input  1  system clock; all state updates on rising edge.
  rst_in  input  1  reset, asynchronous, active-low.
  rdy_in  input  1  global ready; low freezes all state.
  rob_clear  input  1  misprediction flush from the reorder buffer.
  is_commit  input  1  reorder buffer retires its head entry this cycle.
  set_id  input  5  destination register of the retiring entry; 0 means no register write.
  set_val  input  32  result of the retiring entry.
  set_from_rob_id  input  ROB_R  reorder-buffer index of the retiring entry.
  set_dep_id  input  5  destination register renamed by the issuing instruction; 0 means none.
  set_dep_Q  input  ROB_R  reorder-buffer index assigned to the issuing instruction.
  get_id_1, get_id_2  input  5 each  source registers queried by the decoder.
  val_1, val_2  output  32 each  operand value, valid when has_dep_x is 0.
  has_dep_x  output  1 each  operand still pending in the reorder buffer.
  dep_1, dep_2  output  ROB_R each  reorder-buffer tag of a pending operand.
  get_rob_id_1, get_rob_id_2  output  ROB_R each  tag forwarded to the reorder buffer for a value lookup.
  rob_avail_1, rob_avail_2  input  1 each  reorder buffer holds the result for get_rob_id_x.
  rob_val_1, rob_val_2  input  32 each  that result.

Function
REQ-002 The module SHALL keep 32 entries; each entry holds a 32-bit value, a busy bit and a ROB_R-bit dependency tag.
REQ-003 Register x0 SHALL always read as value 0 with has_dep 0; writes and renames targeting x0 SHALL be ignored.
REQ-004 On a clock edge with is_commit=1, rdy_in=1, rob_clear=0 and set_id!=0, value[set_id] SHALL be updated to set_val.
REQ-005 In the same cycle as REQ-004, busy[set_id] SHALL be cleared only if busy[set_id] is 1 and tag[set_id] equals set_from_rob_id.
REQ-006 A commit whose tag is stale (a younger rename exists) SHALL update the value and leave busy and tag unchanged.
REQ-007 On a clock edge with rdy_in=1, rob_clear=0 and set_dep_id!=0, busy[set_dep_id] SHALL be set to 1 and tag[set_dep_id] SHALL be set to set_dep_Q.
REQ-008 When a commit and a rename target the same register in one cycle, the rename SHALL win for busy and tag, and the commit SHALL still write the value.
REQ-009 On a clock edge with rob_clear=1 and rdy_in=1, all busy bits SHALL be cleared, values SHALL be retained, and is_commit and set_dep_id SHALL be ignored in that cycle.
REQ-010 Reads SHALL be combinational with zero-cycle latency and SHALL reflect pre-edge state, so a same-cycle rename is not visible to the same-cycle query.
REQ-011 Read priority for each port x SHALL be, in order:
  (a) get_id_x=0: val 0, no dependency.
  (b) entry not busy: stored value, no dependency.
  (c) busy and is_commit with set_from_rob_id equal to the tag: val = set_val, no dependency.
  (d) busy and rob_avail_x: val = rob_val_x, no dependency.
  (e) otherwise: has_dep_x=1, dep_x = tag.
REQ-012 get_rob_id_x SHALL always equal tag[get_id_x].
REQ-013 When rdy_in=0, no state SHALL change; combinational outputs SHALL still follow current state.
REQ-014 ROB_R-bit tag comparisons SHALL be exact equality; tags wrap with the reorder buffer and need no age ordering.

Reset
REQ-015 While rst_in=0, all values, busy bits and tags SHALL be cleared to 0 immediately, without waiting for clk_in.
REQ-016 After reset, every query SHALL return val 0, has_dep 0 and dep 0.
REQ-017 Reset SHALL override rob_clear, commit and rename.

Structure
REQ-018 ROB_R, ROB_A and the reorder-buffer depth SHALL come from the shared constants file, and no local copies SHALL be made.
REQ-019 The read-priority logic of REQ-011 SHALL be one sub-module, regfile_rd_port, instantiated twice.
REQ-020 The storage and update logic SHALL stay in regfile.

Verification
REQ-021 Scenario: reset, then query x5 -> val 0, has_dep 0; rename x0 to tag 3 -> x0 still reads 0, no dependency.
REQ-022 Scenario: rename x5 to tag 2, next cycle query x5 with rob_avail=0 -> has_dep 1, dep 2; commit set_id=5, val 0xDEADBEEF, rob_id 2 -> x5 reads 0xDEADBEEF, no dependency.
REQ-023 Scenario: rename x7 to tag 1, then x7 to tag 4; commit x7 with rob_id 1, val 0x11 -> value 0x11, busy 1, dep 4.
REQ-024 Scenario: x3 busy with tag 6; commit x3 with rob_id 6 and rename x3 to tag 0 in the same cycle -> value updated, busy 1, dep 0; a same-cycle query of x3 returns set_val with no dependency.
REQ-025 Scenario: x9 busy with tag 5 and rob_avail_1=1, rob_val_1=0x1234 -> val_1 0x1234, has_dep_1 0.
REQ-026 Scenario: assert rob_clear with a concurrent commit to x9 and a rename of x10 -> all busy bits 0, x9 and x10 values unchanged.
REQ-027 Scenario: drop rst_in between clock edges mid-sequence -> state clears before the next edge.
